// File: rtl/uart_spi_pkg.sv
// Shared types and constants for the UART <-> SPI-master word bridge.
package uart_spi_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    WR_DATA,
    POLL,
    RD_DATA,
    EMIT
  } state_e;

  localparam logic [2:0] ADDR_RXDATA = 3'd0;
  localparam logic [2:0] ADDR_TXDATA = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;

  localparam int STATUS_RRDY_BIT = 7;

endpackage

// File: rtl/spi_reg_access.sv
// Two-cycle register access sequencer for the SPI master's register port.
// Valid/ready: start_i is honoured only while idle; done_o pulses in the 2nd bus cycle.
module spi_reg_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        rd_i,
  input  logic [2:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        spi_select_o,
  output logic [2:0]  mem_addr_o,
  output logic        write_n_o,
  output logic        read_n_o,
  output logic [31:0] data_from_cpu_o,
  input  logic [31:0] data_to_cpu_i
);

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_CYC1,
    ACC_CYC2
  } acc_state_e;

  acc_state_e  phase_q;
  logic        sel_q;
  logic        write_n_q;
  logic        read_n_q;
  logic [2:0]  addr_q;
  logic [31:0] wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= ACC_IDLE;
      sel_q     <= 1'b0;
      write_n_q <= 1'b1;
      read_n_q  <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (phase_q)
        ACC_IDLE: begin
          if (start_i) begin
            phase_q   <= ACC_CYC1;
            sel_q     <= 1'b1;
            write_n_q <= rd_i;
            read_n_q  <= ~rd_i;
            addr_q    <= addr_i;
            wdata_q   <= rd_i ? 32'h0 : wdata_i;
          end
        end
        ACC_CYC1: phase_q <= ACC_CYC2;
        ACC_CYC2: begin
          phase_q   <= ACC_IDLE;
          sel_q     <= 1'b0;
          write_n_q <= 1'b1;
          read_n_q  <= 1'b1;
          addr_q    <= '0;
          wdata_q   <= '0;
        end
        default: phase_q <= ACC_IDLE;
      endcase
    end
  end

  // The master's read data is registered, so it is valid by the end of the 2nd cycle.
  assign done_o          = (phase_q == ACC_CYC2);
  assign rdata_o         = data_to_cpu_i;
  assign spi_select_o    = sel_q;
  assign mem_addr_o      = addr_q;
  assign write_n_o       = write_n_q;
  assign read_n_o        = read_n_q;
  assign data_from_cpu_o = wdata_q;

endmodule

// File: rtl/uart_spi_word_bridge.sv
// Packs 4 UART RX bytes into a word for the SPI master, polls RRDY, and
// returns the received word to UART TX MSB first.
module uart_spi_word_bridge
  import uart_spi_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 100000,
  parameter int POLL_LIMIT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        spi_select,
  output logic [2:0]  mem_addr,
  output logic        write_n,
  output logic        read_n,
  output logic [31:0] data_from_cpu,
  input  logic [31:0] data_to_cpu,
  output logic        busy,
  output logic        rx_overrun,
  output logic        spi_timeout
);

  localparam int IDLE_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(BYTE_TIMEOUT - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);

  state_e            state_q;
  logic [1:0]        byte_cnt_q;
  logic [1:0]        emit_cnt_q;
  logic [31:0]       word_q;
  logic [IDLE_W-1:0] idle_q;
  logic [POLL_W-1:0] poll_cnt_q;
  logic              acc_start_q;
  logic              acc_rd_q;
  logic [2:0]        acc_addr_q;
  logic              tx_valid_q;
  logic [7:0]        tx_data_q;
  logic              overrun_q;
  logic              timeout_q;
  logic              acc_done;
  logic [31:0]       acc_rdata;

  spi_reg_access u_acc (
    .clk             (clk),
    .reset           (reset),
    .start_i         (acc_start_q),
    .rd_i            (acc_rd_q),
    .addr_i          (acc_addr_q),
    .wdata_i         (word_q),
    .done_o          (acc_done),
    .rdata_o         (acc_rdata),
    .spi_select_o    (spi_select),
    .mem_addr_o      (mem_addr),
    .write_n_o       (write_n),
    .read_n_o        (read_n),
    .data_from_cpu_o (data_from_cpu),
    .data_to_cpu_i   (data_to_cpu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      byte_cnt_q  <= '0;
      emit_cnt_q  <= '0;
      word_q      <= '0;
      idle_q      <= '0;
      poll_cnt_q  <= '0;
      acc_start_q <= 1'b0;
      acc_rd_q    <= 1'b0;
      acc_addr_q  <= ADDR_RXDATA;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      acc_start_q <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= rx_valid && (state_q != COLLECT);
      case (state_q)
        COLLECT: begin
          if (rx_valid) begin
            word_q <= {word_q[23:0], rx_data};
            idle_q <= '0;
            if (byte_cnt_q == 2'd3) begin
              byte_cnt_q  <= '0;
              state_q     <= WR_DATA;
              acc_start_q <= 1'b1;
              acc_rd_q    <= 1'b0;
              acc_addr_q  <= ADDR_TXDATA;
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end else if (byte_cnt_q != 2'd0) begin
            // A stalled partial word is dropped so the next byte starts a fresh word.
            if (idle_q == IDLE_LAST) begin
              byte_cnt_q <= '0;
              word_q     <= '0;
              idle_q     <= '0;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (acc_done) begin
            state_q     <= POLL;
            poll_cnt_q  <= '0;
            acc_start_q <= 1'b1;
            acc_rd_q    <= 1'b1;
            acc_addr_q  <= ADDR_STATUS;
          end
        end
        POLL: begin
          if (acc_done) begin
            if (acc_rdata[STATUS_RRDY_BIT]) begin
              state_q     <= RD_DATA;
              acc_start_q <= 1'b1;
              acc_rd_q    <= 1'b1;
              acc_addr_q  <= ADDR_RXDATA;
            end else if (poll_cnt_q == POLL_LAST) begin
              timeout_q <= 1'b1;
              word_q    <= '0;
              state_q   <= COLLECT;
            end else begin
              poll_cnt_q  <= poll_cnt_q + 1'b1;
              acc_start_q <= 1'b1;
              acc_rd_q    <= 1'b1;
              acc_addr_q  <= ADDR_STATUS;
            end
          end
        end
        RD_DATA: begin
          if (acc_done) begin
            word_q     <= acc_rdata;
            tx_data_q  <= acc_rdata[31:24];
            tx_valid_q <= 1'b1;
            emit_cnt_q <= '0;
            state_q    <= EMIT;
          end
        end
        EMIT: begin
          // word_q shifts left so its top byte is always the next byte to send.
          if (tx_ready) begin
            if (emit_cnt_q == 2'd3) begin
              tx_valid_q <= 1'b0;
              word_q     <= '0;
              state_q    <= COLLECT;
            end else begin
              emit_cnt_q <= emit_cnt_q + 2'd1;
              tx_data_q  <= word_q[23:16];
              word_q     <= {word_q[23:0], 8'h00};
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign busy        = (state_q != COLLECT);
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign rx_overrun  = overrun_q;
  assign spi_timeout = timeout_q;

endmodule

// File: tb/tb_uart_spi_word_bridge.sv
// Bench for uart_spi_word_bridge: behavioural SPI-master register model, UART TX
// monitor, and per-scenario tasks comparing against words built from the sent bytes.
module tb_uart_spi_word_bridge;

  localparam int BT = 40;
  localparam int PL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        write_n;
  logic        read_n;
  logic [31:0] data_from_cpu;
  logic [31:0] data_to_cpu;
  logic        busy;
  logic        rx_overrun;
  logic        spi_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  uart_spi_word_bridge #(.BYTE_TIMEOUT(BT), .POLL_LIMIT(PL)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .spi_select    (spi_select),
    .mem_addr      (mem_addr),
    .write_n       (write_n),
    .read_n        (read_n),
    .data_from_cpu (data_from_cpu),
    .data_to_cpu   (data_to_cpu),
    .busy          (busy),
    .rx_overrun    (rx_overrun),
    .spi_timeout   (spi_timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  // SPI master register model: committed writes, RRDY after rrdy_after zero polls.
  int          status_reads, data_reads, writes, wr_low, rd_low, bus_err;
  int          rrdy_after;
  int          xfer_status;
  int          sel_run;
  logic        echo_mode;
  logic [31:0] fixed_word, rx_word, last_wdata;
  logic        sel_prev;
  logic [2:0]  acc_addr;
  logic [31:0] acc_wdata;

  always @(posedge clk) begin
    if (reset) begin
      data_to_cpu <= 32'h0;
      sel_prev = 1'b0;
      sel_run  = 0;
    end else begin
      if (!spi_select && (!write_n || !read_n)) bus_err++;
      if (!write_n && !read_n) bus_err++;
      if (!write_n) wr_low++;
      if (!read_n) rd_low++;
      if (spi_select && !sel_prev) begin
        acc_addr  = mem_addr;
        acc_wdata = data_from_cpu;
        sel_run   = 1;
        if (!read_n) begin
          if (mem_addr == 3'd2) begin
            data_to_cpu <= (rrdy_after >= 0 && xfer_status >= rrdy_after) ? 32'h80 : 32'h0;
            status_reads++;
            xfer_status++;
          end else if (mem_addr == 3'd0) begin
            data_to_cpu <= rx_word;
            data_reads++;
          end else begin
            data_to_cpu <= 32'h0;
          end
        end
      end else if (spi_select) begin
        sel_run++;
        if (mem_addr !== acc_addr || data_from_cpu !== acc_wdata) bus_err++;
        if (sel_run == 2 && !write_n) begin
          writes++;
          last_wdata = data_from_cpu;
          if (mem_addr == 3'd1) begin
            rx_word     = echo_mode ? data_from_cpu : fixed_word;
            xfer_status = 0;
          end
        end
      end else if (sel_prev && sel_run != 2) begin
        bus_err++;
      end
      sel_prev = spi_select;
    end
  end

  // UART TX / pulse monitor, sampled mid-cycle
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         ovr_cnt, to_cnt;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (rx_overrun) ovr_cnt++;
      if (spi_timeout) to_cnt++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat ($urandom_range(0, maxgap)) step();
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  task automatic clear_model(input logic echo, input int rrdy, input logic [31:0] fw);
    status_reads = 0; data_reads = 0; writes = 0; wr_low = 0; rd_low = 0; bus_err = 0;
    xfer_status = 0; ovr_cnt = 0; to_cnt = 0;
    echo_mode = echo; rrdy_after = rrdy; fixed_word = fw;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[31-8*i -: 8]);
  endtask

  task automatic measure_latency(output int cyc);
    cyc = 1;
    while (!tx_valid && cyc < 500) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while ((busy || tx_valid) && cyc < 2000) begin
      step();
      cyc++;
    end
    repeat (2) step();
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({spi_select, write_n, read_n, mem_addr} !== {1'b0, 1'b1, 1'b1, 3'd0}) begin
      n_fail++; $display("FAIL reset_bus got %b want 0110000", {spi_select, write_n, read_n, mem_addr});
    end
    n_checks++;
    if (data_from_cpu !== 32'h0) begin
      n_fail++; $display("FAIL reset_wdata got %h want 00000000", data_from_cpu);
    end
    n_checks++;
    if ({tx_valid, tx_data} !== 9'h0) begin
      n_fail++; $display("FAIL reset_tx got %b/%h want 0/00", tx_valid, tx_data);
    end
    n_checks++;
    if ({busy, rx_overrun, spi_timeout} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {busy, rx_overrun, spi_timeout});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_loopback();
    int lat, idle;
    clear_model(1'b1, 0, 32'h0);
    expect_word(32'hDEADBEEF);
    send_word(32'hDEADBEEF, 0);
    measure_latency(lat);
    wait_idle(idle);
    n_checks++;
    if (lat !== 10) begin n_fail++; $display("FAIL loop_latency got %0d want 10", lat); end
    n_checks++;
    if (writes !== 1 || last_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL loop_write got %0d x %h want 1 x deadbeef", writes, last_wdata);
    end
    n_checks++;
    if (wr_low !== 2) begin n_fail++; $display("FAIL loop_write_n_low got %0d want 2", wr_low); end
    n_checks++;
    if (status_reads !== 1 || data_reads !== 1 || bus_err !== 0) begin
      n_fail++; $display("FAIL loop_bus got st=%0d rd=%0d err=%0d want 1 1 0", status_reads, data_reads, bus_err);
    end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL loop_tx_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL loop_tx[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_poll_loop();
    int lat, idle;
    clear_model(1'b0, 5, 32'h12345678);
    expect_word(32'h12345678);
    send_word($urandom, 3);
    measure_latency(lat);
    wait_idle(idle);
    n_checks++;
    if (lat !== 7 + 3 * 6) begin n_fail++; $display("FAIL poll_latency got %0d want %0d", lat, 7 + 3 * 6); end
    n_checks++;
    if (status_reads !== 6 || data_reads !== 1) begin
      n_fail++; $display("FAIL poll_reads got st=%0d rd=%0d want 6 1", status_reads, data_reads);
    end
    n_checks++;
    if (rd_low !== 14 || bus_err !== 0) begin
      n_fail++; $display("FAIL poll_read_n_low got %0d err=%0d want 14 0", rd_low, bus_err);
    end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL poll_tx_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL poll_tx[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int idle;
    clear_model(1'b1, -1, 32'h0);
    send_word($urandom, 2);
    wait_idle(idle);
    n_checks++;
    if (idle >= 2000) begin n_fail++; $display("FAIL to_stuck got busy=%b want 0", busy); end
    n_checks++;
    if (status_reads !== PL || data_reads !== 0) begin
      n_fail++; $display("FAIL to_reads got st=%0d rd=%0d want %0d 0", status_reads, data_reads, PL);
    end
    n_checks++;
    if (to_cnt !== 1) begin n_fail++; $display("FAIL to_pulse got %0d want 1", to_cnt); end
    n_checks++;
    if (got_q.size() !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_idle got tx=%0d busy=%b want 0 0", got_q.size(), busy);
    end
  endtask

  task automatic test_resync();
    int idle;
    clear_model(1'b1, 0, 32'h0);
    send_byte($urandom);
    send_byte($urandom);
    repeat (BT + 1) step();
    expect_word(32'h01020304);
    send_word(32'h01020304, 0);
    wait_idle(idle);
    n_checks++;
    if (writes !== 1 || last_wdata !== 32'h01020304) begin
      n_fail++; $display("FAIL resync_write got %0d x %h want 1 x 01020304", writes, last_wdata);
    end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL resync_tx_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL resync_tx[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overrun();
    int lat, idle, injected;
    logic [31:0] w, w2;
    clear_model(1'b1, 0, 32'h0);
    w = $urandom;
    expect_word(w);
    tx_ready = 1'b0;
    injected = 0;
    send_word(w, 2);
    measure_latency(lat);
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 10; c++) begin
        if (c == 0 || $urandom_range(0, 3) == 0) begin
          rx_data  = $urandom;
          rx_valid = 1'b1;
          injected++;
        end
        step();
        rx_valid = 1'b0;
      end
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    wait_idle(idle);
    n_checks++;
    if (ovr_cnt !== injected) begin n_fail++; $display("FAIL ovr_pulses got %0d want %0d", ovr_cnt, injected); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL ovr_tx_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovr_tx[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    // dropped bytes must not have disturbed byte alignment
    clear_model(1'b1, 0, 32'h0);
    w2 = $urandom;
    send_word(w2, 1);
    wait_idle(idle);
    n_checks++;
    if (writes !== 1 || last_wdata !== w2) begin
      n_fail++; $display("FAIL ovr_next_word got %0d x %h want 1 x %h", writes, last_wdata, w2);
    end
  endtask

  task automatic test_reset_mid();
    int idle;
    logic [31:0] w;
    clear_model(1'b1, 0, 32'h0);
    send_word($urandom, 1);
    step();
    step();
    n_checks++;
    if (spi_select !== 1'b1 || write_n !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_in_write got sel=%b wn=%b want 1 0", spi_select, write_n);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({spi_select, write_n, busy} !== 3'b010) begin
      n_fail++; $display("FAIL rstmid_async got %b want 010", {spi_select, write_n, busy});
    end
    step();
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (writes !== 0) begin n_fail++; $display("FAIL rstmid_no_commit got %0d want 0", writes); end
    clear_model(1'b1, 0, 32'h0);
    w = $urandom;
    expect_word(w);
    send_word(w, 1);
    wait_idle(idle);
    n_checks++;
    if (writes !== 1 || last_wdata !== w) begin
      n_fail++; $display("FAIL rstmid_new_word got %0d x %h want 1 x %h", writes, last_wdata, w);
    end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_tx_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_tx[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int lat, idle, p;
    logic [31:0] w, fw;
    logic echo;
    for (int it = 0; it < 6; it++) begin
      w    = $urandom;
      fw   = $urandom;
      echo = 1'($urandom_range(0, 1));
      p    = $urandom_range(0, 3);
      clear_model(echo, p, fw);
      expect_word(echo ? w : fw);
      send_word(w, BT / 2);
      measure_latency(lat);
      wait_idle(idle);
      n_checks++;
      if (writes !== 1 || last_wdata !== w) begin
        n_fail++; $display("FAIL rand%0d_write got %0d x %h want 1 x %h", it, writes, last_wdata, w);
      end
      n_checks++;
      if (lat !== 7 + 3 * (p + 1) || status_reads !== p + 1 || bus_err !== 0) begin
        n_fail++; $display("FAIL rand%0d_timing got lat=%0d st=%0d err=%0d want %0d %0d 0",
                           it, lat, status_reads, bus_err, 7 + 3 * (p + 1), p + 1);
      end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_tx_count got %0d want %0d", it, got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_tx[%0d] got %h want %h", it, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    clear_model(1'b1, 0, 32'h0);
    rx_word = 32'h0;
    last_wdata = 32'h0;
    test_reset();
    test_loopback();
    test_poll_loop();
    test_timeout();
    test_resync();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
